// File: rtl/passwd_entry_ctrl.sv
// Keypad-to-password-register sequencer: pairs digits onto d1/d2 and strobes y0/y1/y2.
// Define PASSWD_TIMEOUT_EN to build the inactivity auto-abort counter.
module passwd_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TW             = 26
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       reg_clr,
  output logic [2:0] digit_cnt,
  output logic       entry_done,
  output logic       err,
  output logic       timeout
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;
  localparam logic [DW-1:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [DW-1:0] KEY_CANCEL    = 4'hB;
  localparam logic [DW-1:0] KEY_ENTER     = 4'hC;
  localparam logic [CW-1:0] MAX_DIGITS    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_LOAD    = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_d1, w_d1_nxt;
  logic [DW-1:0]   r_d2, w_d2_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_y, w_y_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_reg_clr, w_reg_clr_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic            r_to, w_to_nxt;
  logic            w_accept;
  logic            w_is_digit;
  logic            w_expire;

  assign w_accept   = key_valid & r_ready;
  assign w_is_digit = (key_code <= KEY_MAX_DIGIT);

`ifdef PASSWD_TIMEOUT_EN
  logic [TW-1:0] r_tcnt;

  // Idle counter runs only while a partial or full entry is pending and no strobe is in flight.
  assign w_expire = (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) && (r_cnt != '0) && (r_state != S_LOAD);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_tcnt <= '0;
    end else if (w_accept || (r_cnt == '0) || w_expire) begin
      r_tcnt <= '0;
    end else if (r_state != S_LOAD) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(TW)};
  assign w_expire     = 1'b0;
`endif

  // Next-state and registered-output decode; an accepted key wins over a coincident expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_d1_nxt      = r_d1;
    w_d2_nxt      = r_d2;
    w_cnt_nxt     = r_cnt;
    w_y_nxt       = '0;
    w_reg_clr_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_to_nxt      = 1'b0;

    if (r_state == S_LOAD) begin
      w_state_nxt = (r_cnt == MAX_DIGITS) ? S_FULL : S_COLLECT;
    end else if (w_accept) begin
      if (w_is_digit) begin
        if (r_cnt == MAX_DIGITS) begin
          w_err_nxt = 1'b1;
        end else if (!r_cnt[0]) begin
          w_d1_nxt    = key_code;
          w_d2_nxt    = '0;
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = S_COLLECT;
        end else begin
          // Pair index is cnt/2 before the increment: 1->y0, 3->y1, 5->y2.
          w_d2_nxt    = key_code;
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = S_LOAD;
          w_y_nxt     = 3'b001 << r_cnt[2:1];
        end
      end else if (key_code == KEY_ENTER) begin
        if (r_cnt == MAX_DIGITS) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else if (key_code == KEY_CANCEL) begin
        w_reg_clr_nxt = 1'b1;
        w_d1_nxt      = '0;
        w_d2_nxt      = '0;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_IDLE;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (w_expire) begin
      w_reg_clr_nxt = 1'b1;
      w_to_nxt      = 1'b1;
      w_d1_nxt      = '0;
      w_d2_nxt      = '0;
      w_cnt_nxt     = '0;
      w_state_nxt   = S_IDLE;
    end

    w_ready_nxt = (w_state_nxt != S_LOAD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_d1      <= '0;
      r_d2      <= '0;
      r_cnt     <= '0;
      r_y       <= '0;
      r_ready   <= 1'b1;
      r_reg_clr <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_d1      <= w_d1_nxt;
      r_d2      <= w_d2_nxt;
      r_cnt     <= w_cnt_nxt;
      r_y       <= w_y_nxt;
      r_ready   <= w_ready_nxt;
      r_reg_clr <= w_reg_clr_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_to      <= w_to_nxt;
    end
  end

  assign key_ready  = r_ready;
  assign d1         = r_d1;
  assign d2         = r_d2;
  assign y0         = r_y[0];
  assign y1         = r_y[1];
  assign y2         = r_y[2];
  assign reg_clr    = r_reg_clr;
  assign digit_cnt  = r_cnt;
  assign entry_done = r_done;
  assign err        = r_err;
  assign timeout    = r_to;

endmodule

// File: tb/tb_passwd_entry_ctrl.sv
// Randomized self-checking bench for passwd_entry_ctrl against a digit-queue reference model.
// Timeout scenarios are exercised when PASSWD_TIMEOUT_EN is defined.
module tb_passwd_entry_ctrl;

  localparam int unsigned TO = 20;
`ifdef PASSWD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ready, y0, y1, y2, reg_clr, entry_done, err, timeout;
  logic [3:0] d1, d2;
  logic [2:0] digit_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  passwd_entry_ctrl #(.TIMEOUT_CYCLES(TO), .TW(5)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .d1(d1), .d2(d2), .y0(y0), .y1(y1), .y2(y2),
    .reg_clr(reg_clr), .digit_cnt(digit_cnt), .entry_done(entry_done),
    .err(err), .timeout(timeout)
  );

  // Reference model: the accepted digits live in a queue; pairs and strobes follow from its length.
  int         m_digits[$];
  logic [3:0] m_d1, m_d2;
  bit         m_load;
  int         m_idle;
  logic [2:0] m_y;
  bit         m_err, m_done, m_rclr, m_to;

  logic [18:0] w_dut;
  assign w_dut = {key_ready, d1, d2, y2, y1, y0, reg_clr, digit_cnt, entry_done, err, timeout};

  function automatic logic [18:0] model_vec();
    return {~m_load, m_d1, m_d2, m_y[2], m_y[1], m_y[0], m_rclr,
            3'(m_digits.size()), m_done, m_err, m_to};
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_d1 = 4'h0; m_d2 = 4'h0; m_load = 1'b0; m_idle = 0;
    m_y = 3'b000; m_err = 1'b0; m_done = 1'b0; m_rclr = 1'b0; m_to = 1'b0;
  endtask

  // Predict the effect of one clock edge from the currently driven key, then advance.
  task automatic tick();
    bit acc, expire, nerr, ndone, nrclr, nto, nload;
    logic [2:0] ny;
    int k;
    acc    = key_valid && !m_load;
    expire = TO_EN && (m_digits.size() != 0) && !m_load && (m_idle == int'(TO) - 1);
    k      = int'(key_code);
    ny = 3'b000; nerr = 0; ndone = 0; nrclr = 0; nto = 0; nload = 0;
    if (acc) begin
      m_idle = 0;
      if (k <= 9) begin
        if (m_digits.size() == 6) nerr = 1;
        else begin
          m_digits.push_back(k);
          if (m_digits.size() % 2 == 1) begin
            m_d1 = key_code; m_d2 = 4'h0;
          end else begin
            m_d2 = key_code;
            ny[m_digits.size() / 2 - 1] = 1'b1;
            nload = 1;
          end
        end
      end else if (k == 12) begin
        if (m_digits.size() == 6) begin ndone = 1; m_digits.delete(); end
        else nerr = 1;
      end else if (k == 11) begin
        nrclr = 1; m_digits.delete(); m_d1 = 4'h0; m_d2 = 4'h0;
      end else begin
        nerr = 1;
      end
    end else if (expire) begin
      nrclr = 1; nto = 1; m_digits.delete(); m_d1 = 4'h0; m_d2 = 4'h0; m_idle = 0;
    end else if (m_digits.size() != 0 && !m_load) begin
      m_idle++;
    end else if (m_digits.size() == 0) begin
      m_idle = 0;
    end
    @(posedge clk); #1;
    m_y = ny; m_err = nerr; m_done = ndone; m_rclr = nrclr; m_to = nto; m_load = nload;
  endtask

  task automatic do_reset();
    clr = 1'b0; key_valid = 1'b0; model_reset();
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive(input int c);
    key_valid = (c >= 0);
    key_code  = (c >= 0) ? 4'(c) : 4'hF;
  endtask

  task automatic test_reset();
    clr = 1'b0; key_valid = 1'b0; model_reset();
    #12;
    checks++;
    if (w_dut !== model_vec()) begin
      failures++; $display("FAIL reset_held: got %h expected %h", w_dut, model_vec());
    end
    @(negedge clk); clr = 1'b1;
    tick();
    checks++;
    if (w_dut !== model_vec()) begin
      failures++; $display("FAIL reset_release: got %h expected %h", w_dut, model_vec());
    end
  endtask

  task automatic test_spaced_digits();
    int seq[] = '{1,-1,-1,2,-1,-1,3,-1,-1,4,-1,-1,5,-1,-1,6,-1,-1};
    int ycnt[3] = '{0,0,0};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL spaced[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
      ycnt[0] += int'(y0); ycnt[1] += int'(y1); ycnt[2] += int'(y2);
    end
    drive(-1);
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (ycnt[p] !== 1) begin
        failures++; $display("FAIL spaced_strobe_y%0d: got %0d cycles expected 1", p, ycnt[p]);
      end
    end
    checks++;
    if (digit_cnt !== 3'd6) begin
      failures++; $display("FAIL spaced_cnt: got %0d expected 6", digit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int lowcnt = 0;
    bit acc;
    do_reset();
    drive(int'($urandom_range(0, 9)));
    for (int i = 0; i < 30 && m_digits.size() < 6; i++) begin
      acc = !m_load;
      tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL b2b[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
      if (y0) order.push_back(0);
      if (y1) order.push_back(1);
      if (y2) order.push_back(2);
      if (!key_ready) lowcnt++;
      if (acc) key_code = 4'($urandom_range(0, 9));
    end
    drive(-1);
    checks++;
    if (order.size() !== 3) begin
      failures++; $display("FAIL b2b_strobes: got %0d strobes expected 3", order.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (order[p] !== p) begin
          failures++; $display("FAIL b2b_order[%0d]: got y%0d expected y%0d", p, order[p], p);
        end
      end
    end
    checks++;
    if (lowcnt !== 3) begin
      failures++; $display("FAIL b2b_ready_low: got %0d cycles expected 3", lowcnt);
    end
  endtask

  task automatic test_full_enter();
    int seq[] = '{-1,7,-1,12,-1,12,-1};
    int dones = 0;
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL full_enter[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
      dones += int'(entry_done);
    end
    drive(-1);
    checks++;
    if (dones !== 1 || digit_cnt !== 3'd0) begin
      failures++; $display("FAIL enter_done: got %0d pulses cnt %0d expected 1 pulse cnt 0", dones, digit_cnt);
    end
  endtask

  task automatic test_cancel();
    int seq[] = '{7,-1,8,-1,-1,9,-1,14,-1,12,-1,11,-1};
    int y0s = 0, clrs = 0;
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL cancel[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
      y0s += int'(y0); clrs += int'(reg_clr);
    end
    drive(-1);
    checks++;
    if (y0s !== 1 || clrs !== 1 || d1 !== 4'h0 || d2 !== 4'h0 || digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL cancel_final: got y0=%0d reg_clr=%0d d1=%h d2=%h cnt=%0d expected 1 1 0 0 0",
               y0s, clrs, d1, d2, digit_cnt);
    end
  endtask

  task automatic test_timeout();
    int tos = 0;
    do_reset();
    drive(3); tick(); drive(-1);
`ifdef PASSWD_TIMEOUT_EN
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL timeout_idle[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
      tos += int'(timeout);
    end
    checks++;
    if (tos !== 1) begin
      failures++; $display("FAIL timeout_pulses: got %0d expected 1", tos);
    end
    drive(4); tick(); drive(-1);
    for (int i = 0; i < 40 && m_idle != int'(TO) - 1; i++) begin
      tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL timeout_wait[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
    end
    drive(11); tick(); drive(-1);
    checks++;
    if (reg_clr !== 1'b1 || timeout !== 1'b0 || w_dut !== model_vec()) begin
      failures++; $display("FAIL cancel_on_expiry: got %h expected %h", w_dut, model_vec());
    end
`else
    for (int i = 0; i < 60; i++) begin
      tick();
      tos += int'(timeout);
    end
    checks++;
    if (tos !== 0 || digit_cnt !== 3'd1 || d1 !== 4'h3) begin
      failures++; $display("FAIL hold_no_timeout: got %0d pulses cnt %0d d1 %h expected 0 1 3", tos, digit_cnt, d1);
    end
`endif
  endtask

  task automatic test_clr_mid_load();
    int seq[] = '{1,-1,2,-1,-1,3,-1,4};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL midload[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
    end
    drive(-1);
    checks++;
    if (y1 !== 1'b1) begin
      failures++; $display("FAIL midload_y1_before: got %b expected 1", y1);
    end
    clr = 1'b0; model_reset();
    #1;
    checks++;
    if (w_dut !== model_vec()) begin
      failures++; $display("FAIL midload_async_clr: got %h expected %h", w_dut, model_vec());
    end
    #2 clr = 1'b1;
    tick();
    drive(5); tick(); drive(-1);
    checks++;
    if (d1 !== 4'h5 || digit_cnt !== 3'd1 || w_dut !== model_vec()) begin
      failures++; $display("FAIL midload_resume: got %h expected %h", w_dut, model_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        key_valid = 1'b1;
        key_code  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end else begin
        key_valid = 1'b0;
      end
      tick();
      checks++;
      if (w_dut !== model_vec()) begin
        failures++; $display("FAIL random[%0d]: got %h expected %h", i, w_dut, model_vec());
      end
    end
    drive(-1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spaced_digits();
    test_back_to_back();
    test_full_enter();
    test_cancel();
    test_timeout();
    test_clr_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
